// File: rtl/nnet_pkg.sv
// nnet_pkg: shared constants and types for the nnet CE output path.
//   - settings-bus / readback addresses used by the nnet block
//   - CHDR tuser width carried alongside each sample
//   - framer state enum and the packet-length selection helper
package nnet_pkg;

  localparam int SR_USER_SPP    = 131;
  localparam int RB_SIZE_INPUT  = 129;
  localparam int RB_SIZE_OUTPUT = 130;

  localparam int CHDR_USER_W    = 128;
  localparam int AXIS_DATA_W    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } framer_state_t;

  // SPP of 0, or larger than the vector, means "one packet per vector".
  function automatic logic [15:0] pkt_len_sel(input logic [15:0] spp,
                                              input logic [15:0] size);
    return ((spp == 16'd0) || (spp > size)) ? size : spp;
  endfunction

endpackage

// File: rtl/nnet_skid_buf.sv
// nnet_skid_buf: 2-entry ready/valid register slice.
//   Outputs are fully registered; in_ready depends only on local state, so
//   the slice breaks both the data and the ready timing paths while still
//   sustaining one transfer per cycle.
// Ports:
//   clk, reset_n (async, active low), clear (sync flush)
//   in_data/in_valid/in_ready    upstream side
//   out_data/out_valid/out_ready downstream side
module nnet_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  // The skid slot only fills while the output is stalled, so accepting
  // whenever it is empty can never lose a beat.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (clear) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_data <= in_data;
        end
      end
    end else if (in_valid && !skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/nnet_output_framer.sv
// nnet_output_framer: frames the bare HLS result stream into CHDR packets.
//   Counts samples per inference vector, cuts each vector into packets of
//   the user SPP, generates tlast and attaches the tuser header captured for
//   the vector. Output is registered through a 2-entry skid buffer.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | no vector active; waiting for a queued header to start the next
//   RUN   | vector active; accepting HLS samples until vec_len are taken
//
// Ports:
//   clk, reset_n (async, active low), clear (sync flush, keeps spp_reg)
//   set_stb/set_addr/set_data  settings bus (SPP register)
//   nnet_size_out              samples per inference vector
//   spp_out                    SPP register readback
//   hdr_tdata/tvalid/tready    tuser header input (4-entry FIFO)
//   s_tdata/tvalid/tready      HLS result stream
//   o_tdata/tuser/tlast/tvalid/tready  framed stream to axi_wrapper
//   cfg_err                    sticky: zero vector size seen at vector start
module nnet_output_framer #(
  parameter int SR_USER_SPP    = nnet_pkg::SR_USER_SPP,
  parameter int DATA_W         = 16,
  parameter int HDR_DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         set_stb,
  input  logic [7:0]   set_addr,
  input  logic [31:0]  set_data,
  input  logic [15:0]  nnet_size_out,
  output logic [15:0]  spp_out,
  input  logic [127:0] hdr_tdata,
  input  logic         hdr_tvalid,
  output logic         hdr_tready,
  input  logic [31:0]  s_tdata,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [31:0]  o_tdata,
  output logic [127:0] o_tuser,
  output logic         o_tlast,
  output logic         o_tvalid,
  input  logic         o_tready,
  output logic         cfg_err
);

  import nnet_pkg::*;

  localparam logic [7:0]  SPP_ADDR  = 8'(SR_USER_SPP);
  localparam logic [31:0] DATA_MASK = (DATA_W >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << DATA_W) - 32'd1);
  localparam int HDR_DEPTH = 1 << HDR_DEPTH_LOG2;
  localparam int OUT_W     = 32 + CHDR_USER_W + 1;

  // Bits that are deliberately dropped: upper settings data and the HLS
  // result bits above DATA_W.
  logic unused_bits;
  assign unused_bits = ^{set_data[31:16], s_tdata & ~DATA_MASK};

  // SPP register (survives clear)
  logic [15:0] spp_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spp_reg <= '0;
    end else if (set_stb && (set_addr == SPP_ADDR)) begin
      spp_reg <= set_data[15:0];
    end
  end

  assign spp_out = spp_reg;

  // Header FIFO
  logic [HDR_DEPTH_LOG2:0]  wr_ptr;
  logic [HDR_DEPTH_LOG2:0]  rd_ptr;
  logic [CHDR_USER_W-1:0]   hdr_mem [HDR_DEPTH];
  logic                     hdr_empty;
  logic                     hdr_full;
  logic                     hdr_push;
  logic                     hdr_pop;

  assign hdr_empty  = (wr_ptr == rd_ptr);
  assign hdr_full   = (wr_ptr[HDR_DEPTH_LOG2] != rd_ptr[HDR_DEPTH_LOG2]) &&
                      (wr_ptr[HDR_DEPTH_LOG2-1:0] == rd_ptr[HDR_DEPTH_LOG2-1:0]);
  assign hdr_tready = !hdr_full;
  assign hdr_push   = hdr_tvalid && hdr_tready;

  always_ff @(posedge clk) begin
    if (hdr_push) begin
      hdr_mem[wr_ptr[HDR_DEPTH_LOG2-1:0]] <= hdr_tdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (hdr_push) wr_ptr <= wr_ptr + 1'b1;
      if (hdr_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Framer FSM
  framer_state_t          state;
  framer_state_t          state_nxt;
  logic [CHDR_USER_W-1:0] hdr_hold;
  logic [15:0]            vec_len;
  logic [15:0]            pkt_len;
  logic [15:0]            vec_cnt;
  logic [15:0]            pkt_cnt;
  logic                   vec_last;
  logic                   pkt_last;
  logic                   tlast;
  logic                   beat;
  logic                   cfg_err_set;
  logic                   skid_in_ready;

  // pkt_len/vec_len are at least 1 whenever RUN is active, so the -1 never
  // underflows in a way that matters.
  assign vec_last = (vec_cnt == vec_len - 16'd1);
  assign pkt_last = (pkt_cnt == pkt_len - 16'd1);
  assign tlast    = pkt_last || vec_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hdr_pop     = 1'b0;
    cfg_err_set = 1'b0;
    beat        = 1'b0;
    s_tready    = 1'b0;
    case (state)
      IDLE: begin
        if (!hdr_empty) begin
          if (nnet_size_out == 16'd0) begin
            // Leave the header queued so a corrected size can still use it.
            cfg_err_set = 1'b1;
          end else begin
            hdr_pop   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        s_tready = skid_in_ready;
        if (s_tvalid && skid_in_ready) begin
          beat = 1'b1;
          if (vec_last) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_hold <= '0;
      vec_len  <= '0;
      pkt_len  <= '0;
      vec_cnt  <= '0;
      pkt_cnt  <= '0;
      cfg_err  <= 1'b0;
    end else if (clear) begin
      hdr_hold <= '0;
      vec_len  <= '0;
      pkt_len  <= '0;
      vec_cnt  <= '0;
      pkt_cnt  <= '0;
      cfg_err  <= 1'b0;
    end else begin
      if (cfg_err_set) begin
        cfg_err <= 1'b1;
      end
      if (hdr_pop) begin
        // Size and SPP are sampled only here, so mid-vector changes wait
        // for the next vector.
        hdr_hold <= hdr_mem[rd_ptr[HDR_DEPTH_LOG2-1:0]];
        vec_len  <= nnet_size_out;
        pkt_len  <= pkt_len_sel(spp_reg, nnet_size_out);
        vec_cnt  <= '0;
        pkt_cnt  <= '0;
      end else if (beat) begin
        vec_cnt <= vec_cnt + 16'd1;
        pkt_cnt <= tlast ? 16'd0 : pkt_cnt + 16'd1;
      end
    end
  end

  // Output register slice
  logic [OUT_W-1:0] skid_in;
  logic [OUT_W-1:0] skid_out;

  assign skid_in = {s_tdata & DATA_MASK, hdr_hold, tlast};

  nnet_skid_buf #(
    .WIDTH (OUT_W)
  ) u_out_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_data   (skid_in),
    .in_valid  (beat),
    .in_ready  (skid_in_ready),
    .out_data  (skid_out),
    .out_valid (o_tvalid),
    .out_ready (o_tready)
  );

  assign o_tdata = skid_out[OUT_W-1 -: 32];
  assign o_tuser = skid_out[CHDR_USER_W:1];
  assign o_tlast = skid_out[0];

endmodule

// File: tb/tb_nnet_output_framer.sv
// tb_nnet_output_framer: directed bench for nnet_output_framer.
// Inputs change 1 time unit after the rising edge; outputs and handshakes
// are sampled on the falling edge.
module tb_nnet_output_framer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         clear = 1'b0;
  logic         set_stb = 1'b0;
  logic [7:0]   set_addr = '0;
  logic [31:0]  set_data = '0;
  logic [15:0]  nnet_size_out = '0;
  logic [15:0]  spp_out;
  logic [127:0] hdr_tdata = '0;
  logic         hdr_tvalid = 1'b0;
  logic         hdr_tready;
  logic [31:0]  s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [31:0]  o_tdata;
  logic [127:0] o_tuser;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready = 1'b1;
  logic         cfg_err;

  always #5 clk = ~clk;

  nnet_output_framer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .set_stb       (set_stb),
    .set_addr      (set_addr),
    .set_data      (set_data),
    .nnet_size_out (nnet_size_out),
    .spp_out       (spp_out),
    .hdr_tdata     (hdr_tdata),
    .hdr_tvalid    (hdr_tvalid),
    .hdr_tready    (hdr_tready),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .o_tdata       (o_tdata),
    .o_tuser       (o_tuser),
    .o_tlast       (o_tlast),
    .o_tvalid      (o_tvalid),
    .o_tready      (o_tready),
    .cfg_err       (cfg_err)
  );

  localparam logic [127:0] H1  = 128'h1111_0001_2222_0001_3333_0001_4444_0001;
  localparam logic [127:0] H2  = 128'hA5A5_0002_5A5A_0002_DEAD_0002_BEEF_0002;
  localparam logic [127:0] H3A = 128'h0000_0000_0000_0000_0000_0000_0000_3A3A;
  localparam logic [127:0] H3B = 128'h3B3B_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] H4  = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
  localparam logic [127:0] H5A = 128'h0005_000A_0005_000A_0005_000A_0005_000A;
  localparam logic [127:0] H5B = 128'h0005_000B_0005_000B_0005_000B_0005_000B;
  localparam logic [127:0] H6  = 128'h6666_0000_6666_0000_6666_0000_6666_0006;
  localparam logic [127:0] H8D = 128'h8888_DDDD_8888_DDDD_8888_DDDD_8888_DDDD;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0]  got_data [$];
  logic [127:0] got_user [$];
  logic         got_last [$];
  int           got_cyc  [$];
  int           acc_cyc  [$];

  logic         stab_en = 1'b0;
  logic         prev_stall = 1'b0;
  logic [32:0]  prev_dl = '0;
  logic [127:0] prev_user = '0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_tvalid && s_tready) acc_cyc.push_back(cyc);
    if (o_tvalid && o_tready) begin
      got_data.push_back(o_tdata);
      got_user.push_back(o_tuser);
      got_last.push_back(o_tlast);
      got_cyc.push_back(cyc);
    end
    if (stab_en && prev_stall) begin
      chk("stall_valid", o_tvalid, 1'b1);
      chk("stall_data", {o_tlast, o_tdata}, prev_dl);
      chk("stall_user", o_tuser, prev_user);
    end
    prev_stall <= o_tvalid && !o_tready;
    prev_dl    <= {o_tlast, o_tdata};
    prev_user  <= o_tuser;
  end

  task automatic flush_q();
    got_data.delete();
    got_user.delete();
    got_last.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    tick(1);
    set_stb  = 1'b0;
  endtask

  task automatic push_hdr(input logic [127:0] h);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    hdr_tvalid = 1'b1;
    hdr_tdata  = h;
    do begin
      @(negedge clk);
      ok = hdr_tready;
      tick(1);
      t++;
    end while (!ok && t < 50);
    hdr_tvalid = 1'b0;
    chk("hdr_push_ok", ok, 1'b1);
  endtask

  task automatic push_samples(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int   t;
      logic acc;
      t   = 0;
      acc = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = base + 32'(i);
      do begin
        @(negedge clk);
        acc = s_tready;
        tick(1);
        t++;
      end while (!acc && t < 200);
      chk("sample_push_ok", acc, 1'b1);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n);
    int t;
    t = 0;
    while (got_data.size() < n && t < 500) begin
      tick(1);
      t++;
    end
    tick(4);
    chk(tag, got_data.size(), n);
  endtask

  function automatic logic [31:0] last_map();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < got_last.size() && i < 32; i++) m[i] = got_last[i];
    return m;
  endfunction

  task automatic chk_data(input string tag, input int first, input int n, input logic [31:0] exp_base);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (first + i >= got_data.size() || got_data[first + i] !== exp_base + 32'(i)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic chk_user(input string tag, input int first, input int n, input logic [127:0] exp);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (first + i >= got_user.size() || got_user[first + i] !== exp) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    // Reset state
    #2 reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_o_tvalid", o_tvalid, 1'b0);
    chk("rst_o_tlast", o_tlast, 1'b0);
    chk("rst_o_tdata", o_tdata, 32'h0);
    chk("rst_o_tuser", o_tuser, 128'h0);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_hdr_tready", hdr_tready, 1'b1);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_spp_out", spp_out, 16'h0);
    tick(1);

    // 1: SPP=0, size 10 -> single 10-sample packet
    flush_q();
    nnet_size_out = 16'd10;
    push_hdr(H1);
    push_samples(10, 32'h5A5A_0100);
    wait_beats("t1_count", 10);
    chk_data("t1_data", 0, 10, 32'h0000_0100);
    chk("t1_tlast_map", last_map(), 32'h0000_0200);
    chk_user("t1_tuser", 0, 10, H1);
    chk("t1_latency", got_cyc[0] - acc_cyc[0], 1);

    // 2: SPP=4, size 10 -> 4,4,2
    flush_q();
    wr_reg(8'd131, 32'hFFFF_0004);
    wr_reg(8'd130, 32'h0000_0007);
    @(negedge clk);
    chk("t2_spp_out", spp_out, 16'd4);
    tick(1);
    push_hdr(H2);
    push_samples(10, 32'hFFFF_0200);
    wait_beats("t2_count", 10);
    chk_data("t2_data", 0, 10, 32'h0000_0200);
    chk("t2_tlast_map", last_map(), 32'h0000_0288);
    chk_user("t2_tuser", 0, 10, H2);

    // 3: back-to-back vectors, size 3
    flush_q();
    wr_reg(8'd131, 32'h0);
    nnet_size_out = 16'd3;
    push_hdr(H3A);
    push_hdr(H3B);
    push_samples(6, 32'h0000_0300);
    wait_beats("t3_count", 6);
    chk_data("t3_data", 0, 6, 32'h0000_0300);
    chk("t3_tlast_map", last_map(), 32'h0000_0024);
    chk_user("t3_tuser_a", 0, 3, H3A);
    chk_user("t3_tuser_b", 3, 3, H3B);
    chk("t3_throughput", got_cyc[1] - got_cyc[0], 1);
    chk("t3_idle_gap_out", got_cyc[3] - got_cyc[2], 2);
    chk("t3_idle_gap_in", acc_cyc[3] - acc_cyc[2], 2);

    // 4: random o_tready, data masking, stall stability
    flush_q();
    nnet_size_out = 16'd8;
    push_hdr(H4);
    stab_en = 1'b1;
    fork
      push_samples(8, 32'hABCD_1230);
      begin
        for (int k = 0; k < 400 && got_data.size() < 8; k++) begin
          o_tready = 1'($urandom_range(0, 1));
          tick(1);
        end
        o_tready = 1'b1;
      end
    join
    wait_beats("t4_count", 8);
    stab_en = 1'b0;
    chk_data("t4_data", 0, 8, 32'h0000_1230);
    chk("t4_sample4", got_data[4], 32'h0000_1234);
    chk("t4_tlast_map", last_map(), 32'h0000_0080);
    chk_user("t4_tuser", 0, 8, H4);

    // 5: SPP and size changed mid-vector apply to the next vector only
    flush_q();
    nnet_size_out = 16'd6;
    push_hdr(H5A);
    push_samples(3, 32'h0000_0500);
    wr_reg(8'd131, 32'h0000_0002);
    nnet_size_out = 16'd9;
    push_samples(3, 32'h0000_0503);
    tick(2);
    nnet_size_out = 16'd6;
    push_hdr(H5B);
    push_samples(6, 32'h0000_0506);
    wait_beats("t5_count", 12);
    chk_data("t5_data", 0, 12, 32'h0000_0500);
    chk("t5_tlast_map", last_map(), 32'h0000_0AA0);
    chk_user("t5_tuser_a", 0, 6, H5A);
    chk_user("t5_tuser_b", 6, 6, H5B);

    // 6: zero vector size -> cfg_err, header kept
    flush_q();
    nnet_size_out = 16'd0;
    push_hdr(H6);
    tick(3);
    @(negedge clk);
    chk("t6_cfg_err", cfg_err, 1'b1);
    chk("t6_s_tready", s_tready, 1'b0);
    tick(1);
    push_hdr(128'h6B);
    push_hdr(128'h6C);
    push_hdr(128'h6D);
    @(negedge clk);
    chk("t6_fifo_full", hdr_tready, 1'b0);
    tick(1);
    nnet_size_out = 16'd2;
    push_samples(2, 32'h0000_0600);
    wait_beats("t6_count", 2);
    chk_user("t6_tuser", 0, 2, H6);
    chk("t6_tlast_map", last_map(), 32'h0000_0002);
    chk("t6_cfg_err_sticky", cfg_err, 1'b1);

    // 7: async reset mid-packet
    flush_q();
    o_tready = 1'b0;
    push_samples(1, 32'h0000_0700);
    @(negedge clk);
    chk("t7_pre_valid", o_tvalid, 1'b1);
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_o_tvalid", o_tvalid, 1'b0);
    chk("t7_o_tdata", o_tdata, 32'h0);
    chk("t7_o_tuser", o_tuser, 128'h0);
    chk("t7_s_tready", s_tready, 1'b0);
    chk("t7_hdr_tready", hdr_tready, 1'b1);
    chk("t7_cfg_err", cfg_err, 1'b0);
    chk("t7_spp_out", spp_out, 16'h0);
    tick(1);
    reset_n = 1'b1;
    flush_q();
    o_tready = 1'b1;
    s_tvalid = 1'b1;
    tick(6);
    s_tvalid = 1'b0;
    chk("t7_fifo_empty", acc_cyc.size(), 0);
    chk("t7_no_output", got_data.size(), 0);

    // 8: synchronous clear mid-packet keeps SPP
    wr_reg(8'd131, 32'h0000_0003);
    nnet_size_out = 16'd5;
    push_hdr(128'h8A);
    push_hdr(128'h8B);
    push_hdr(128'h8C);
    o_tready = 1'b0;
    push_samples(2, 32'h0000_0800);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    flush_q();
    @(negedge clk);
    chk("t8_o_tvalid", o_tvalid, 1'b0);
    chk("t8_o_tdata", o_tdata, 32'h0);
    chk("t8_o_tuser", o_tuser, 128'h0);
    chk("t8_s_tready", s_tready, 1'b0);
    chk("t8_hdr_tready", hdr_tready, 1'b1);
    chk("t8_spp_out", spp_out, 16'd3);
    tick(1);
    o_tready = 1'b1;
    s_tvalid = 1'b1;
    tick(6);
    s_tvalid = 1'b0;
    chk("t8_fifo_empty", acc_cyc.size(), 0);
    flush_q();
    push_hdr(H8D);
    push_samples(5, 32'h0000_0810);
    wait_beats("t8_count", 5);
    chk_data("t8_data", 0, 5, 32'h0000_0810);
    chk("t8_tlast_map", last_map(), 32'h0000_0014);
    chk_user("t8_tuser", 0, 5, H8D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
